regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, >=2, need not be a power of 2.
REQ-003 SHALL have parameter INITIAL_VALUE, default {WIDTH{1'b0}}: reset, clear and power-up value of every entry and of both read outputs.
REQ-004 SHALL derive AW = $clog2(DEPTH) as the address width.
REQ-005 SHALL have the following ports:
- CLK  in  1  clock; one clock domain; all state updates on posedge.
- RST  in  1  reset; synchronous, active-high.
- WE  in  1  write enable.
- WA  in  AW  write address.
- WD  in  WIDTH  write data.
- RE0  in  1  read enable, port 0.
- RA0  in  AW  read address, port 0.
- RQ0  out  WIDTH  registered read data, port 0.
- RE1  in  1  read enable, port 1.
- RA1  in  AW  read address, port 1.
- RQ1  out  WIDTH  registered read data, port 1.
- CLR  in  1  clear request; starts a sweep.
- BUSY  out  1  sweep in progress; registered.

Function
REQ-006 SHALL write WD to entry WA at a posedge when WE=1, RST=0 and BUSY=0.
REQ-007 SHALL ignore the write when WA >= DEPTH, with no side effects.
REQ-008 SHALL ignore WE while BUSY=1; the write is dropped, not queued.
REQ-009 SHALL update each read port with 1-cycle latency: when REn=1 at a posedge, RQn SHALL equal entry RAn after that edge.
REQ-010 SHALL hold RQn unchanged when REn=0.
REQ-011 SHALL return INITIAL_VALUE on RQn when REn=1 and RAn >= DEPTH.
REQ-012 SHALL allow both ports to read the same or different addresses in the same cycle, independently.
REQ-013 SHALL use a two-state FSM, IDLE and SWEEP:
- IDLE->SWEEP: CLR=1 at a posedge while IDLE.
- SWEEP->IDLE: after the cycle that clears entry DEPTH-1.
REQ-014 SHALL, in SWEEP, write INITIAL_VALUE to entry k in the k-th sweep cycle, k = 0..DEPTH-1, one entry per cycle.
REQ-015 SHALL assert BUSY for exactly DEPTH consecutive cycles, beginning the cycle after the CLR edge.
REQ-016 SHALL ignore CLR while in SWEEP; the sweep is not restarted or extended.
REQ-017 SHALL service reads during SWEEP: an entry already swept reads INITIAL_VALUE; an entry not yet swept reads its old value.
REQ-018 SHALL treat CLR=1 together with WE=1 while IDLE as follows: the write commits on that edge and the sweep then clears it.

Reset
REQ-019 SHALL, on a posedge with RST=1, set:
- all entries to INITIAL_VALUE;
- RQ0 and RQ1 to INITIAL_VALUE;
- the FSM to IDLE, BUSY to 0 and the sweep counter to 0.
REQ-020 SHALL give RST priority over WE, CLR, RE0 and RE1 in the same cycle.
REQ-021 SHALL abort a sweep in progress on RST; BUSY=0 after that edge.
REQ-022 SHALL power up all flops, including RQn, at INITIAL_VALUE, with BUSY=0.

Configuration
REQ-023 SHALL support macro REGFILE_BYPASS_EN:
- Defined: a read issued in the same cycle as a committed write to the same address returns the new data. This covers both the WD port write and the sweep write of INITIAL_VALUE.
- Undefined: that read returns the pre-write contents; no forwarding logic is present.

Structure
REQ-024 SHALL place the FSM state enum typedef (IDLE, SWEEP) in the shared package regfile_pkg.
REQ-025 SHALL have one sub-module, regfile_sweep_ctrl, containing the FSM, the sweep counter and BUSY. It outputs the sweep write-enable and the sweep address.
REQ-026 SHALL keep the storage array and read registers in regfile_2r1w.

Verification
REQ-027 SHALL cover write-then-read: WE=1, WA=3, WD=0xA5; next cycle RE0=1, RA0=3 -> RQ0=0xA5 one cycle later; RQ1 unchanged.
REQ-028 SHALL cover the same-cycle collision: WE=1, WA=5, WD=0x3C; RE1=1, RA1=5; prior contents 0x00 -> RQ1=0x3C with REGFILE_BYPASS_EN defined, 0x00 without.
REQ-029 SHALL cover a full sweep: fill all 16 entries with 0xFF, pulse CLR -> BUSY=1 for exactly 16 cycles. A WE to entry 2 during BUSY is dropped. All entries then read 0x00.
REQ-030 SHALL cover reset mid-sweep: RST=1 in sweep cycle 7 -> BUSY=0 on the next edge, all entries 0x00, RQ0=RQ1=0x00.
REQ-031 SHALL cover a non-power-of-2 depth: DEPTH=10; WE=1, WA=12 -> no entry changes; RE0=1, RA0=12 -> RQ0=INITIAL_VALUE.
REQ-032 SHALL cover read hold: RE0=0 for 5 cycles while entry RA0 is rewritten -> RQ0 keeps its last value.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types for the 2R1W register file and its clear sweep.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// rtl/regfile_sweep_ctrl.sv - clear-sweep FSM: walks entries 0..DEPTH-1 writing the init value.
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_sweep_we,
  output logic [AW-1:0] o_sweep_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  sweep_state_e  r_state;
  sweep_state_e  w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // CLR is only looked at in IDLE, so a request during a sweep is simply lost.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_sweep_we   = 1'b0;
    o_sweep_addr = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_clr) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        o_sweep_we = 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == SWEEP);

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with registered reads and clear sweep.
// Define REGFILE_BYPASS_EN to forward a same-cycle committed write to the read ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int               WIDTH         = 8,
  parameter  int               DEPTH         = 16,
  parameter  logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}},
  localparam int               AW            = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic             RE0,
  input  logic [AW-1:0]    RA0,
  output logic [WIDTH-1:0] RQ0,
  input  logic             RE1,
  input  logic [AW-1:0]    RA1,
  output logic [WIDTH-1:0] RQ1,
  input  logic             CLR,
  output logic             BUSY
);

  // One extra bit so the range check stays meaningful when DEPTH is a power of 2.
  localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rq0;
  logic [WIDTH-1:0] r_rq1;

  logic             w_busy;
  logic             w_sweep_we;
  logic [AW-1:0]    w_sweep_addr;
  logic             w_usr_we;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;
  logic             w_ra0_ok;
  logic             w_ra1_ok;
  logic [WIDTH-1:0] w_rd0;
  logic [WIDTH-1:0] w_rd1;

  regfile_sweep_ctrl #(
    .DEPTH (DEPTH)
  ) u_sweep_ctrl (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_clr        (CLR),
    .o_busy       (w_busy),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_addr (w_sweep_addr)
  );

  // User writes only happen while idle, so they never collide with the sweep.
  assign w_usr_we   = WE && !w_busy && ({1'b0, WA} < DEPTH_EXT);
  assign w_mem_we   = w_sweep_we || w_usr_we;
  assign w_mem_addr = w_sweep_we ? w_sweep_addr : WA;
  assign w_mem_data = w_sweep_we ? INITIAL_VALUE : WD;

  assign w_ra0_ok = ({1'b0, RA0} < DEPTH_EXT);
  assign w_ra1_ok = ({1'b0, RA1} < DEPTH_EXT);

  always_comb begin
    w_rd0 = INITIAL_VALUE;
    w_rd1 = INITIAL_VALUE;
    if (w_ra0_ok) begin
`ifdef REGFILE_BYPASS_EN
      w_rd0 = (w_mem_we && (w_mem_addr == RA0)) ? w_mem_data : r_mem[RA0];
`else
      w_rd0 = r_mem[RA0];
`endif
    end
    if (w_ra1_ok) begin
`ifdef REGFILE_BYPASS_EN
      w_rd1 = (w_mem_we && (w_mem_addr == RA1)) ? w_mem_data : r_mem[RA1];
`else
      w_rd1 = r_mem[RA1];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INITIAL_VALUE;
      end
    end else if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rq0 <= INITIAL_VALUE;
      r_rq1 <= INITIAL_VALUE;
    end else begin
      if (RE0) r_rq0 <= w_rd0;
      if (RE1) r_rq1 <= w_rd1;
    end
  end

  assign RQ0  = r_rq0;
  assign RQ1  = r_rq1;
  assign BUSY = w_busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed self-checking bench for regfile_2r1w (DEPTH 16 and 10).
// Collision expectation follows REGFILE_BYPASS_EN.
module tb_regfile_2r1w;

  logic       clk = 1'b0;
  logic       rst, we, re0, re1, clr, busy;
  logic [3:0] wa, ra0, ra1;
  logic [7:0] wd, rq0, rq1;

  logic       b_we, b_re0, b_re1, b_clr, b_busy;
  logic [3:0] b_wa, b_ra0, b_ra1;
  logic [7:0] b_wd, b_rq0, b_rq1;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(8), .DEPTH(16), .INITIAL_VALUE(8'h00)) dut (
    .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
    .RE0(re0), .RA0(ra0), .RQ0(rq0), .RE1(re1), .RA1(ra1), .RQ1(rq1),
    .CLR(clr), .BUSY(busy)
  );

  regfile_2r1w #(.WIDTH(8), .DEPTH(10), .INITIAL_VALUE(8'h00)) dut10 (
    .CLK(clk), .RST(rst), .WE(b_we), .WA(b_wa), .WD(b_wd),
    .RE0(b_re0), .RA0(b_ra0), .RQ0(b_rq0), .RE1(b_re1), .RA1(b_ra1), .RQ1(b_rq1),
    .CLR(b_clr), .BUSY(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    we = 0; re0 = 0; re1 = 0; clr = 0; wa = 0; ra0 = 0; ra1 = 0; wd = 0;
  endtask

  task automatic test_reset;
    rst = 1; tick; tick; rst = 0;
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("FAIL reset_busy got %b want 0", busy); end
    vec_count++; if (rq0 !== 8'h00) begin err_count++; $display("FAIL reset_rq0 got %h want 00", rq0); end
    vec_count++; if (rq1 !== 8'h00) begin err_count++; $display("FAIL reset_rq1 got %h want 00", rq1); end
    vec_count++; if (b_busy !== 1'b0) begin err_count++; $display("FAIL reset_b_busy got %b want 0", b_busy); end
  endtask

  task automatic test_write_read;
    we = 1; wa = 1; wd = 8'h11; tick; we = 0;
    re1 = 1; ra1 = 1; tick; re1 = 0;
    vec_count++; if (rq1 !== 8'h11) begin err_count++; $display("FAIL wr_rd_rq1_prime got %h want 11", rq1); end
    we = 1; wa = 3; wd = 8'hA5; tick; we = 0;
    re0 = 1; ra0 = 3; tick; re0 = 0;
    vec_count++; if (rq0 !== 8'hA5) begin err_count++; $display("FAIL wr_rd_rq0 got %h want a5", rq0); end
    vec_count++; if (rq1 !== 8'h11) begin err_count++; $display("FAIL wr_rd_rq1_hold got %h want 11", rq1); end
  endtask

  task automatic test_collision;
    logic [7:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 8'h3C;
`else
    exp = 8'h00;
`endif
    we = 1; wa = 5; wd = 8'h3C; re1 = 1; ra1 = 5; tick; we = 0; re1 = 0;
    vec_count++; if (rq1 !== exp) begin err_count++; $display("FAIL collision_rq1 got %h want %h", rq1, exp); end
    re1 = 1; tick; re1 = 0;
    vec_count++; if (rq1 !== 8'h3C) begin err_count++; $display("FAIL collision_after got %h want 3c", rq1); end
  endtask

  task automatic test_dual_read;
    re0 = 1; ra0 = 3; re1 = 1; ra1 = 3; tick;
    vec_count++; if (rq0 !== 8'hA5) begin err_count++; $display("FAIL dual_same_rq0 got %h want a5", rq0); end
    vec_count++; if (rq1 !== 8'hA5) begin err_count++; $display("FAIL dual_same_rq1 got %h want a5", rq1); end
    ra0 = 5; ra1 = 1; tick; re0 = 0; re1 = 0;
    vec_count++; if (rq0 !== 8'h3C) begin err_count++; $display("FAIL dual_diff_rq0 got %h want 3c", rq0); end
    vec_count++; if (rq1 !== 8'h11) begin err_count++; $display("FAIL dual_diff_rq1 got %h want 11", rq1); end
  endtask

  task automatic test_read_hold;
    re0 = 1; ra0 = 3; tick; re0 = 0;
    vec_count++; if (rq0 !== 8'hA5) begin err_count++; $display("FAIL hold_prime got %h want a5", rq0); end
    for (int i = 0; i < 5; i++) begin
      we = 1; wa = 3; wd = 8'(8'h60 + i); tick;
      vec_count++; if (rq0 !== 8'hA5) begin err_count++; $display("FAIL hold_cycle%0d got %h want a5", i, rq0); end
    end
    we = 0; re0 = 1; tick; re0 = 0;
    vec_count++; if (rq0 !== 8'h64) begin err_count++; $display("FAIL hold_reread got %h want 64", rq0); end
  endtask

  task automatic test_sweep;
    int n;
    for (int i = 0; i < 16; i++) begin
      we = 1; wa = 4'(i); wd = 8'hFF; tick;
    end
    we = 0;
    clr = 1; tick; clr = 0;
    n = 0;
    while (busy && n < 40) begin
      re0 = 1; ra0 = 15; re1 = 1; ra1 = 0;
      we = (n == 3); wa = 2; wd = 8'h77;
      clr = (n == 5);
      tick;
      if (n >= 1 && n <= 14) begin
        vec_count++; if (rq0 !== 8'hFF) begin err_count++; $display("FAIL sweep_unswept_c%0d got %h want ff", n, rq0); end
        vec_count++; if (rq1 !== 8'h00) begin err_count++; $display("FAIL sweep_swept_c%0d got %h want 00", n, rq1); end
      end
      n++;
    end
    idle_inputs();
    vec_count++; if (n !== 16) begin err_count++; $display("FAIL sweep_busy_len got %0d want 16", n); end
    for (int i = 0; i < 8; i++) begin
      re0 = 1; ra0 = 4'(2 * i); re1 = 1; ra1 = 4'(2 * i + 1); tick;
      vec_count++; if (rq0 !== 8'h00) begin err_count++; $display("FAIL sweep_entry%0d got %h want 00", 2 * i, rq0); end
      vec_count++; if (rq1 !== 8'h00) begin err_count++; $display("FAIL sweep_entry%0d got %h want 00", 2 * i + 1, rq1); end
    end
    re0 = 0; re1 = 0;
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("FAIL sweep_no_restart got %b want 0", busy); end
  endtask

  task automatic test_clr_with_we;
    int n;
    we = 1; wa = 4; wd = 8'h42; clr = 1; tick; we = 0; clr = 0;
    vec_count++; if (busy !== 1'b1) begin err_count++; $display("FAIL clrwe_busy got %b want 1", busy); end
    re0 = 1; ra0 = 4; tick; re0 = 0;
    vec_count++; if (rq0 !== 8'h42) begin err_count++; $display("FAIL clrwe_committed got %h want 42", rq0); end
    n = 0;
    while (busy && n < 40) begin tick; n++; end
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("FAIL clrwe_timeout busy %b want 0", busy); end
    re0 = 1; ra0 = 4; tick; re0 = 0;
    vec_count++; if (rq0 !== 8'h00) begin err_count++; $display("FAIL clrwe_cleared got %h want 00", rq0); end
  endtask

  task automatic test_reset_mid_sweep;
    for (int i = 0; i < 16; i++) begin
      we = 1; wa = 4'(i); wd = 8'(i + 1); tick;
    end
    we = 0;
    re0 = 1; ra0 = 15; re1 = 1; ra1 = 14; tick; re0 = 0; re1 = 0;
    vec_count++; if (rq0 !== 8'h10) begin err_count++; $display("FAIL rstmid_prime_rq0 got %h want 10", rq0); end
    vec_count++; if (rq1 !== 8'h0F) begin err_count++; $display("FAIL rstmid_prime_rq1 got %h want 0f", rq1); end
    clr = 1; tick; clr = 0;
    for (int i = 0; i < 7; i++) tick;
    rst = 1; re0 = 1; ra0 = 15; re1 = 1; ra1 = 14; we = 1; wa = 9; wd = 8'hAA; clr = 1;
    tick;
    rst = 0; idle_inputs();
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vec_count++; if (rq0 !== 8'h00) begin err_count++; $display("FAIL rstmid_rq0 got %h want 00", rq0); end
    vec_count++; if (rq1 !== 8'h00) begin err_count++; $display("FAIL rstmid_rq1 got %h want 00", rq1); end
    for (int i = 0; i < 8; i++) begin
      re0 = 1; ra0 = 4'(2 * i); re1 = 1; ra1 = 4'(2 * i + 1); tick;
      vec_count++; if (rq0 !== 8'h00) begin err_count++; $display("FAIL rstmid_entry%0d got %h want 00", 2 * i, rq0); end
      vec_count++; if (rq1 !== 8'h00) begin err_count++; $display("FAIL rstmid_entry%0d got %h want 00", 2 * i + 1, rq1); end
    end
    re0 = 0; re1 = 0;
    vec_count++; if (busy !== 1'b0) begin err_count++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
  endtask

  task automatic test_depth10;
    b_we = 1; b_wa = 9; b_wd = 8'h5A; tick;
    b_wa = 12; b_wd = 8'h99; tick; b_we = 0;
    b_re0 = 1; b_ra0 = 9; tick;
    vec_count++; if (b_rq0 !== 8'h5A) begin err_count++; $display("FAIL d10_entry9 got %h want 5a", b_rq0); end
    b_ra0 = 12; tick; b_re0 = 0;
    vec_count++; if (b_rq0 !== 8'h00) begin err_count++; $display("FAIL d10_oob_read got %h want 00", b_rq0); end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] exp;
      exp = (i == 9) ? 8'h5A : 8'h00;
      b_re1 = 1; b_ra1 = 4'(i); tick;
      vec_count++; if (b_rq1 !== exp) begin err_count++; $display("FAIL d10_entry%0d got %h want %h", i, b_rq1, exp); end
    end
    b_re1 = 0;
  endtask

  initial begin
    rst = 1; idle_inputs();
    b_we = 0; b_re0 = 0; b_re1 = 0; b_clr = 0; b_wa = 0; b_ra0 = 0; b_ra1 = 0; b_wd = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_dual_read();
    test_read_hold();
    test_sweep();
    test_clr_with_we();
    test_reset_mid_sweep();
    test_depth10();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
